// File: rtl/btn_debouncer.sv
// btn_debouncer: per-channel 2-flop synchronizer plus debounce FSM with registered level and press/release pulses
module btn_debouncer #(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  logic [N_BTN-1:0] sync_a, sync_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= i_btn;
      sync_b <= sync_a;
    end
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t        st;
    logic [CW-1:0] cnt;
    logic          lvl, prs, rls;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st  <= IDLE;
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        prs <= 1'b0;
        rls <= 1'b0;
        case (st)
          IDLE:
            if (sync_b[g]) begin
              st  <= PRESS_WAIT;
              cnt <= CW'(1);
            end
          PRESS_WAIT:
            if (!sync_b[g]) begin
              st  <= IDLE;
              cnt <= '0;
            end else if (cnt == LAST) begin
              st  <= HELD;
              cnt <= '0;
              lvl <= 1'b1;
              prs <= 1'b1;
            end else cnt <= cnt + CW'(1);
          HELD:
            if (!sync_b[g]) begin
              st  <= RELEASE_WAIT;
              cnt <= CW'(1);
            end
          default:
            if (sync_b[g]) begin
              st  <= HELD;
              cnt <= '0;
            end else if (cnt == LAST) begin
              st  <= IDLE;
              cnt <= '0;
              lvl <= 1'b0;
              rls <= 1'b1;
            end else cnt <= cnt + CW'(1);
        endcase
      end
    assign o_btn_level[g]   = lvl;
    assign o_btn_press[g]   = prs;
    assign o_btn_release[g] = rls;
  end
endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: directed stimulus checked against a run-length debounce model plus literal latency checks
module tb_btn_debouncer;
  localparam int N  = 5;
  localparam int DB = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_btn = '0;
  logic [N-1:0] lvl, prs, rel;
  int checks = 0, failures = 0;
  logic running = 1'b0;

  btn_debouncer #(.N_BTN(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn),
    .o_btn_level(lvl), .o_btn_press(prs), .o_btn_release(rel)
  );

  always #5 clk = ~clk;

  // Model: the level flips once the synchronized input has disagreed with it for DB consecutive samples.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
  int run [N];
  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] nl, np, nr;
    int nrun;
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_prs <= '0; m_rel <= '0;
      for (int i = 0; i < N; i++) run[i] <= 0;
    end else begin
      nl = m_lvl; np = '0; nr = '0;
      for (int i = 0; i < N; i++) begin
        nrun = (m_s2[i] != m_lvl[i]) ? run[i] + 1 : 0;
        if (nrun == DB) begin
          nl[i] = ~m_lvl[i];
          np[i] = nl[i];
          nr[i] = ~nl[i];
          nrun = 0;
        end
        run[i] <= nrun;
      end
      m_lvl <= nl; m_prs <= np; m_rel <= nr;
      m_s2 <= m_s1; m_s1 <= i_btn;
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (running) begin
    check("model_level", lvl, m_lvl);
    check("model_press", prs, m_prs);
    check("model_release", rel, m_rel);
    check("press_and_release_overlap", prs & rel, '0);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    i_btn = v;
    edges(n);
  endtask

  initial begin
    #1;
    check("reset_level", lvl, '0);
    check("reset_press", prs, '0);
    check("reset_release", rel, '0);
    running = 1'b1;
    edges(2);
    #2 rst_n = 1'b1;
    edges(3);
    // Clean press on channel 0: next edge is edge 1
    i_btn = 5'b00001;
    edges(9);
    check("clean_press_e9", prs, 5'b00000);
    edges(1);
    check("clean_press_e10", prs, 5'b00001);
    check("clean_level_e10", lvl, 5'b00001);
    edges(1);
    check("clean_press_e11", prs, 5'b00000);
    edges(9);
    i_btn = 5'b00000;
    edges(9);
    check("clean_release_e9", rel, 5'b00000);
    edges(1);
    check("clean_release_e10", rel, 5'b00001);
    check("clean_level_off", lvl, 5'b00000);
    edges(1);
    check("clean_release_e11", rel, 5'b00000);
    // Press bounce on channel 2
    hold(5'b00100, 3); hold(5'b00000, 2); hold(5'b00100, 3); hold(5'b00000, 15);
    check("bounce_level", lvl, 5'b00000);
    // Release glitch on channel 1
    hold(5'b00010, 14);
    check("glitch_held", lvl, 5'b00010);
    hold(5'b00000, 4); hold(5'b00010, 15);
    check("glitch_level", lvl, 5'b00010);
    hold(5'b00000, 14);
    check("glitch_released", lvl, 5'b00000);
    // Simultaneous press on channels 1 and 3
    i_btn = 5'b01010;
    edges(9);
    check("simul_press_e9", prs, 5'b00000);
    edges(1);
    check("simul_press_e10", prs, 5'b01010);
    edges(1);
    check("simul_press_e11", prs, 5'b00000);
    hold(5'b00010, 14);
    // Reset mid-count on channel 0 with channel 1 held
    i_btn = 5'b00011;
    edges(7);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_level", lvl, 5'b00000);
    check("midreset_press", prs, 5'b00000);
    check("midreset_release", rel, 5'b00000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    edges(9);
    check("postreset_press_e9", prs, 5'b00000);
    edges(1);
    check("postreset_press_e10", prs, 5'b00011);
    hold(5'b00000, 14);
    check("final_level", lvl, 5'b00000);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter N_BTN, default 5: number of independent button channels.
REQ-002 Parameter DB_CYCLES, default 500_000 (20 ms at 25 MHz clk): consecutive stable cycles required to accept a level change; legal range ≥ 2.
REQ-003 clk  input  1  system clock (25 MHz divided clock); one clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_btn  input  N_BTN  raw, asynchronous, bouncing push-button levels; 1 = pressed.
REQ-006 o_btn_level  output  N_BTN  debounced button level per channel.
REQ-007 o_btn_press  output  N_BTN  one-cycle pulse per channel on accepted press (0→1).
REQ-008 o_btn_release  output  N_BTN  one-cycle pulse per channel on accepted release (1→0).

Function
REQ-009 Each channel SHALL pass i_btn[i] through a 2-flop synchronizer; only the second flop (sync[i]) SHALL feed the channel state machine.
REQ-010 Each channel SHALL own an independent FSM {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} and counter cnt of width $clog2(DB_CYCLES); channels SHALL share no state.
REQ-011 IDLE: sync=1 → PRESS_WAIT, cnt←1; else stay.
REQ-012 PRESS_WAIT: sync=0 → IDLE, cnt←0, no pulse; sync=1 and cnt==DB_CYCLES-1 → HELD, o_btn_level←1, o_btn_press←1 for exactly one cycle; otherwise cnt←cnt+1.
REQ-013 HELD: sync=0 → RELEASE_WAIT, cnt←1; else stay.
REQ-014 RELEASE_WAIT: sync=1 → HELD, cnt←0, no pulse, level stays 1; sync=0 and cnt==DB_CYCLES-1 → IDLE, o_btn_level←0, o_btn_release←1 for exactly one cycle; otherwise cnt←cnt+1.
REQ-015 All outputs SHALL be registered; press/release pulses SHALL deassert on the next edge unconditionally.
REQ-016 Latency: with i_btn[i] first sampled high at edge 1 and held, o_btn_press[i] and o_btn_level[i] SHALL go high after edge DB_CYCLES+2; release latency SHALL be symmetric.
REQ-017 Any sync reversal before the count completes SHALL restart qualification from the opposite state; no partial count SHALL survive.
REQ-018 o_btn_press[i] and o_btn_release[i] SHALL never be high in the same cycle; a press pulse SHALL always coincide with the 0→1 edge of o_btn_level[i], a release pulse with its 1→0 edge.
REQ-019 Simultaneous qualifying events on several channels SHALL produce pulses in the same cycle on all of them.
REQ-020 cnt SHALL never exceed DB_CYCLES-1; no wrap-around occurs.

Reset
REQ-021 rst_n=0 SHALL immediately (asynchronously) force synchronizer flops, cnt, o_btn_level, o_btn_press and o_btn_release to 0 and every FSM to IDLE.
REQ-022 Reset mid-qualification SHALL discard the partial count and emit no pulse.
REQ-023 A button held high across reset release SHALL be treated as a new press: pulse after DB_CYCLES+2 edges.

Verification (DB_CYCLES=8, N_BTN=5)
REQ-024 Clean press: i_btn[0]=1 from edge 1 for 20 cycles, then 0 -> o_btn_press[0]=1 only in the cycle after edge 10, o_btn_level[0]=1 from edge 10; o_btn_release[0] one cycle, 10 edges after the falling sample; no other bit toggles.
REQ-025 Press bounce: i_btn[2] high 3 cycles, low 2, high 3, low -> o_btn_level[2] stays 0, no press or release pulse.
REQ-026 Release glitch: channel 1 in HELD, i_btn[1] low 4 cycles then high -> no release pulse, o_btn_level[1] stays 1.
REQ-027 Simultaneous: i_btn[1] and i_btn[3] rise at same edge -> o_btn_press[1] and o_btn_press[3] high in the same single cycle.
REQ-028 Reset mid-count: channel 0 in PRESS_WAIT with cnt=5, rst_n pulled low between edges -> all outputs 0 immediately, no pulse; rst_n released with i_btn[0] still high -> press pulse after edge 10 counted from release.
